// File: rtl/uart_tx_arb.sv
// Round-robin arbiter granting N requesters access to a single UART transmitter.
// Define UART_TX_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no pointer).
module uart_tx_arb #(
  parameter int data_bits = 8,
  parameter int nreq      = 4
) (
  input  logic                      bclk,
  input  logic                      rst_n,
  input  logic [nreq-1:0]           req,
  input  logic [nreq*data_bits-1:0] req_data,
  input  logic                      txd_done,
  output logic                      txd_startH,
  output logic [data_bits-1:0]      tx_data,
  output logic [nreq-1:0]           gnt,
  output logic [nreq-1:0]           ack,
  output logic                      busy
);

  localparam int PW = (nreq > 2) ? $clog2(nreq) : 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [PW-1:0]          w_win;
  logic                   w_start_nxt;
  logic [data_bits-1:0]   w_data_nxt;
  logic [nreq-1:0]        w_gnt_nxt;
  logic [nreq-1:0]        w_ack_nxt;
  logic                   w_busy_nxt;

  function automatic logic [PW-1:0] f_lowest(input logic [nreq-1:0] v);
    logic [PW-1:0] r;
    r = '0;
    for (int unsigned i = nreq; i > 0; i--) begin
      if (v[i-1]) r = PW'(i-1);
    end
    return r;
  endfunction

`ifdef UART_TX_ARB_FIXED_PRIO_EN
  assign w_win = f_lowest(req);
`else
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_win;
  logic [nreq-1:0] w_upper;

  // Requests at or above the pointer take precedence; otherwise wrap to the lowest.
  always_comb begin
    w_upper = '0;
    for (int unsigned i = 0; i < nreq; i++) begin
      w_upper[i] = req[i] && (PW'(i) >= r_ptr);
    end
  end

  assign w_win = (|w_upper) ? f_lowest(w_upper) : f_lowest(req);
`endif

  // State and registered outputs
  always_ff @(posedge bclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      txd_startH <= 1'b0;
      tx_data    <= '0;
      gnt        <= '0;
      ack        <= '0;
      busy       <= 1'b0;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
      r_ptr      <= '0;
      r_win      <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      txd_startH <= w_start_nxt;
      tx_data    <= w_data_nxt;
      gnt        <= w_gnt_nxt;
      ack        <= w_ack_nxt;
      busy       <= w_busy_nxt;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
      if (r_state == S_IDLE && (|req)) r_win <= w_win;
      if (r_state == S_DONE) begin
        r_ptr <= (r_win == PW'(nreq-1)) ? '0 : r_win + 1'b1;
      end
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (|req) w_state_nxt = S_START;
      S_START: w_state_nxt = S_WAIT;
      S_WAIT:  if (txd_done) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the output registers, so every output comes straight from a flop.
  always_comb begin
    w_start_nxt = 1'b0;
    w_ack_nxt   = '0;
    w_gnt_nxt   = gnt;
    w_data_nxt  = tx_data;
    w_busy_nxt  = (w_state_nxt != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_start_nxt = 1'b1;
          w_gnt_nxt   = '0;
          w_gnt_nxt[w_win] = 1'b1;
          w_data_nxt  = req_data[w_win*data_bits +: data_bits];
        end
      end
      S_WAIT:  if (txd_done) w_ack_nxt = gnt;
      S_DONE:  w_gnt_nxt = '0;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb against a transaction-level arbitration model.
module tb_uart_tx_arb;
  localparam int NREQ = 4;
  localparam int DB   = 8;

  logic                 bclk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ*DB-1:0]   req_data = '0;
  logic                 txd_done = 1'b0;
  logic                 txd_startH;
  logic [DB-1:0]        tx_data;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      ack;
  logic                 busy;

  int n_checks = 0;
  int n_fail   = 0;
  int m_ptr    = 0;

  uart_tx_arb #(.data_bits(DB), .nreq(NREQ)) dut (
    .bclk(bclk), .rst_n(rst_n), .req(req), .req_data(req_data), .txd_done(txd_done),
    .txd_startH(txd_startH), .tx_data(tx_data), .gnt(gnt), .ack(ack), .busy(busy)
  );

  always #5 bclk = ~bclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge bclk);
    #1;
  endtask

  function automatic int model_pick(input logic [NREQ-1:0] r, input int p);
`ifdef UART_TX_ARB_FIXED_PRIO_EN
    for (int k = 0; k < NREQ; k++) if (r[k]) return k;
`else
    for (int k = 0; k < NREQ; k++) if (r[(p + k) % NREQ]) return (p + k) % NREQ;
`endif
    return -1;
  endfunction

  task automatic run_frame(input int wait_cyc, input bit scramble, input bit drop_early,
                           input bit keep_req, output int obs);
    int w;
    logic [DB-1:0] d;
    logic [NREQ-1:0] g;
    w = model_pick(req, m_ptr);
    d = req_data[w*DB +: DB];
    g = '0;
    g[w] = 1'b1;
    tick;
    obs = -1;
    for (int i = 0; i < NREQ; i++) if (gnt[i] && $countones(gnt) == 1) obs = i;
    n_checks++; if (gnt !== g) begin n_fail++; $display("FAIL grant: got %b expected %b", gnt, g); end
    n_checks++; if (tx_data !== d) begin n_fail++; $display("FAIL grant_data: got %h expected %h", tx_data, d); end
    n_checks++;
    if (txd_startH !== 1'b1 || busy !== 1'b1 || ack !== '0) begin
      n_fail++; $display("FAIL start_cycle: start=%b busy=%b ack=%b expected 1 1 0000", txd_startH, busy, ack);
    end
    if (drop_early) req[w] = 1'b0;
    if (scramble) req_data = $urandom;
    tick;
    n_checks++;
    if (txd_startH !== 1'b0 || gnt !== g || busy !== 1'b1) begin
      n_fail++; $display("FAIL wait_entry: start=%b gnt=%b busy=%b expected 0 %b 1", txd_startH, gnt, busy, g);
    end
    repeat (wait_cyc) begin
      if (scramble) req_data = $urandom;
      tick;
      n_checks++;
      if (ack !== '0 || gnt !== g || tx_data !== d || busy !== 1'b1) begin
        n_fail++; $display("FAIL wait_hold: ack=%b gnt=%b data=%h busy=%b expected 0000 %b %h 1", ack, gnt, tx_data, busy, g, d);
      end
    end
    txd_done = 1'b1;
    tick;
    txd_done = 1'b0;
    n_checks++;
    if (ack !== g || gnt !== g || busy !== 1'b1 || txd_startH !== 1'b0) begin
      n_fail++; $display("FAIL ack_pulse: ack=%b gnt=%b busy=%b expected %b %b 1", ack, gnt, busy, g, g);
    end
    if (!keep_req) req[w] = 1'b0;
    tick;
    n_checks++;
    if (ack !== '0 || gnt !== '0 || busy !== 1'b0 || tx_data !== d) begin
      n_fail++; $display("FAIL gap: ack=%b gnt=%b busy=%b data=%h expected 0000 0000 0 %h", ack, gnt, busy, tx_data, d);
    end
`ifndef UART_TX_ARB_FIXED_PRIO_EN
    m_ptr = (w + 1) % NREQ;
`endif
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    n_checks++;
    if ({txd_startH, tx_data, gnt, ack, busy} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 0", {txd_startH, tx_data, gnt, ack, busy});
    end
    tick;
    rst_n = 1'b1;
    m_ptr = 0;
    tick;
    n_checks++;
    if (busy !== 1'b0 || gnt !== '0 || txd_startH !== 1'b0) begin
      n_fail++; $display("FAIL idle_no_req: busy=%b gnt=%b start=%b expected 0", busy, gnt, txd_startH);
    end
  endtask

  task automatic test_single;
    int obs;
    req_data = $urandom;
    req_data[2*DB +: DB] = 8'hA5;
    req = 4'b0100;
    run_frame(3, 1'b0, 1'b0, 1'b0, obs);
    n_checks++; if (obs !== 2) begin n_fail++; $display("FAIL single_winner: got %0d expected 2", obs); end
    req = '0;
  endtask

  task automatic test_all_rr;
    int obs;
`ifdef UART_TX_ARB_FIXED_PRIO_EN
    int exp_order[5] = '{0, 0, 0, 0, 0};
`else
    int exp_order[5] = '{0, 1, 2, 3, 0};
`endif
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    m_ptr = 0;
    req = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      req_data = $urandom;
      run_frame(f % 3, 1'b0, 1'b0, 1'b1, obs);
      n_checks++;
      if (obs !== exp_order[f]) begin
        n_fail++; $display("FAIL rr_order[%0d]: got %0d expected %0d", f, obs, exp_order[f]);
      end
    end
    req = '0;
  endtask

  task automatic test_data_stability;
    int obs;
    req = 4'($urandom_range(1, 15));
    req_data = $urandom;
    run_frame(4, 1'b1, 1'b0, 1'b0, obs);
    req = '0;
  endtask

  task automatic test_spurious_done;
    int w;
    logic [NREQ-1:0] g;
    req = '0;
    txd_done = 1'b1;
    tick;
    txd_done = 1'b0;
    n_checks++;
    if (ack !== '0 || busy !== 1'b0 || gnt !== '0) begin
      n_fail++; $display("FAIL done_in_idle: ack=%b busy=%b gnt=%b expected 0", ack, busy, gnt);
    end
    req = 4'b1000;
    req_data = $urandom;
    w = model_pick(req, m_ptr);
    g = '0;
    g[w] = 1'b1;
    tick;
    n_checks++;
    if (gnt !== g || txd_startH !== 1'b1) begin
      n_fail++; $display("FAIL spur_grant: gnt=%b start=%b expected %b 1", gnt, txd_startH, g);
    end
    txd_done = 1'b1;
    tick;
    txd_done = 1'b0;
    n_checks++;
    if (ack !== '0 || txd_startH !== 1'b0 || busy !== 1'b1 || gnt !== g) begin
      n_fail++; $display("FAIL done_in_start: ack=%b start=%b busy=%b gnt=%b expected 0000 0 1 %b", ack, txd_startH, busy, gnt, g);
    end
    tick;
    n_checks++;
    if (ack !== '0 || gnt !== g || busy !== 1'b1) begin
      n_fail++; $display("FAIL still_waiting: ack=%b gnt=%b busy=%b expected 0000 %b 1", ack, gnt, busy, g);
    end
    txd_done = 1'b1;
    tick;
    txd_done = 1'b0;
    n_checks++; if (ack !== g) begin n_fail++; $display("FAIL spur_ack: got %b expected %b", ack, g); end
    req = '0;
    tick;
    n_checks++;
    if (gnt !== '0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL spur_gap: gnt=%b busy=%b expected 0000 0", gnt, busy);
    end
`ifndef UART_TX_ARB_FIXED_PRIO_EN
    m_ptr = (w + 1) % NREQ;
`endif
  endtask

  task automatic test_reset_mid_frame;
    int obs;
    req = 4'b0010;
    req_data = $urandom;
    tick;
    n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL pre_reset_grant: got %b expected 0010", gnt); end
    tick;
    tick;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({txd_startH, tx_data, gnt, ack, busy} !== '0) begin
      n_fail++; $display("FAIL mid_reset_outputs: got %h expected 0", {txd_startH, tx_data, gnt, ack, busy});
    end
    req = 4'b0011;
    txd_done = 1'b1;
    tick;
    txd_done = 1'b0;
    n_checks++; if (ack !== '0) begin n_fail++; $display("FAIL mid_reset_ack: got %b expected 0000", ack); end
    rst_n = 1'b1;
    m_ptr = 0;
    req_data = $urandom;
    run_frame(1, 1'b0, 1'b0, 1'b0, obs);
    n_checks++; if (obs !== 0) begin n_fail++; $display("FAIL post_reset_winner: got %0d expected 0", obs); end
    req = '0;
  endtask

  task automatic test_withdrawn;
    int obs;
    req = 4'b0110;
    req_data = $urandom;
    run_frame(2, 1'b0, 1'b1, 1'b0, obs);
    n_checks++; if (obs !== 1) begin n_fail++; $display("FAIL withdrawn_winner: got %0d expected 1", obs); end
    req_data = $urandom;
    run_frame(1, 1'b0, 1'b0, 1'b0, obs);
    n_checks++; if (obs !== 2) begin n_fail++; $display("FAIL after_withdraw: got %0d expected 2", obs); end
    req = '0;
  endtask

  task automatic test_random;
    int obs;
    for (int f = 0; f < 24; f++) begin
      if (req == '0) req = 4'($urandom_range(1, 15));
      else req = req | 4'($urandom_range(0, 15));
      req_data = $urandom;
      run_frame(int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), obs);
    end
    req = '0;
  endtask

  initial begin
    test_reset;
    test_single;
    test_all_rr;
    test_data_stability;
    test_spurious_done;
    test_reset_mid_frame;
    test_withdrawn;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
